// File: rtl/block_state_sequencer.sv
// Table-driven next-state engine: each accepted step tests one block bit and moves to one of two programmed successors.
// Adds a run-time-writable transition table, a per-state dwell hold-off and a forced-state override.
module block_state_sequencer #(
    parameter int NUM_BLOCKS  = 7,
    parameter int SEL_W       = 3,
    parameter int STATE_W     = 4,
    parameter int DWELL_W     = 8,
    parameter int RESET_STATE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_BLOCKS-1:0] blocks,
    input  logic                  step_valid,
    output logic                  step_ready,
    input  logic                  force_valid,
    input  logic [STATE_W-1:0]    force_state,
    input  logic                  cfg_we,
    input  logic [STATE_W-1:0]    cfg_addr,
    input  logic [SEL_W-1:0]      cfg_sel,
    input  logic [STATE_W-1:0]    cfg_next_set,
    input  logic [STATE_W-1:0]    cfg_next_clr,
    input  logic [DWELL_W-1:0]    cfg_dwell,
    output logic [STATE_W-1:0]    state,
    output logic                  state_changed,
    output logic                  sel_error
);

    localparam int unsigned ENTRIES = 1 << STATE_W;
    localparam int unsigned NUM_SEL = 1 << SEL_W;
    localparam logic [STATE_W-1:0] RST_VAL = STATE_W'(RESET_STATE);

    typedef enum logic {IDLE, DWELL} fsm_t;

    fsm_t               fsm;
    logic [DWELL_W-1:0] cnt;

    logic [SEL_W-1:0]   sel_tab   [ENTRIES];
    logic [STATE_W-1:0] set_tab   [ENTRIES];
    logic [STATE_W-1:0] clr_tab   [ENTRIES];
    logic [DWELL_W-1:0] dwell_tab [ENTRIES];

    logic [NUM_SEL-1:0] blocks_ext;
    logic [SEL_W-1:0]   cur_sel;
    logic               sel_bad;
    logic [STATE_W-1:0] nxt;
    logic [DWELL_W-1:0] nxt_dwell;
    logic               accept;

    // Table reads see the pre-edge contents, so a same-cycle write never affects the step.
    always_comb begin
        blocks_ext = NUM_SEL'(blocks);
        cur_sel    = sel_tab[state];
        sel_bad    = 32'(cur_sel) >= NUM_BLOCKS;
        nxt        = blocks_ext[cur_sel] ? set_tab[state] : clr_tab[state];
        nxt_dwell  = dwell_tab[nxt];
        accept     = step_valid && step_ready && !force_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                sel_tab[i]   <= '0;
                set_tab[i]   <= RST_VAL;
                clr_tab[i]   <= RST_VAL;
                dwell_tab[i] <= '0;
            end
        end else if (cfg_we) begin
            sel_tab[cfg_addr]   <= cfg_sel;
            set_tab[cfg_addr]   <= cfg_next_set;
            clr_tab[cfg_addr]   <= cfg_next_clr;
            dwell_tab[cfg_addr] <= cfg_dwell;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm           <= IDLE;
            cnt           <= '0;
            state         <= RST_VAL;
            step_ready    <= 1'b1;
            state_changed <= 1'b0;
            sel_error     <= 1'b0;
        end else begin
            state_changed <= 1'b0;
            sel_error     <= 1'b0;
            if (force_valid) begin
                state         <= force_state;
                state_changed <= force_state != state;
                fsm           <= IDLE;
                cnt           <= '0;
                step_ready    <= 1'b1;
            end else begin
                case (fsm)
                    IDLE: begin
                        if (accept) begin
                            if (sel_bad) begin
                                sel_error <= 1'b1;
                            end else begin
                                state         <= nxt;
                                state_changed <= nxt != state;
                                if (nxt_dwell != '0) begin
                                    fsm        <= DWELL;
                                    cnt        <= nxt_dwell;
                                    step_ready <= 1'b0;
                                end
                            end
                        end
                    end
                    DWELL: begin
                        // Leave on the edge where the count would hit zero: ready stays low exactly D cycles.
                        if (cnt == DWELL_W'(1)) begin
                            fsm        <= IDLE;
                            cnt        <= '0;
                            step_ready <= 1'b1;
                        end else begin
                            cnt <= cnt - DWELL_W'(1);
                        end
                    end
                    default: begin
                        fsm        <= IDLE;
                        cnt        <= '0;
                        step_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
